// File: rtl/riscv_pkg.sv
// riscv_pkg: load/store size encodings and LSU state type shared by the split LSU.
package riscv_pkg;
  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, HI, ERR} lsu_state_t;
endpackage

// File: rtl/riscv_lsu_split_if.sv
// riscv_lsu_split_if: core-side access port and memory beat port of the split LSU.
interface riscv_lsu_split_if #(parameter int ADDR_W = 32) ();
  logic              core_req_i;
  logic              core_we_i;
  logic [2:0]        core_size_i;
  logic [ADDR_W-1:0] core_addr_i;
  logic [31:0]       core_wd_i;
  logic [31:0]       core_rd_o;
  logic              core_stall_o;
  logic              core_fault_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wd_o;
  logic [31:0]       mem_rd_i;
  logic              mem_ready_i;
  modport master (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_o, core_fault_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
  modport slave (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_o, core_fault_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: byte-lane enables, store data steering and load extraction/extension.
module riscv_lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  input  logic        hi,
  input  logic [31:0] wd,
  input  logic [31:0] rd,
  input  logic [31:0] lo,
  output logic [3:0]  be,
  output logic [31:0] lane_wd,
  output logic [31:0] ld
);
  logic [3:0]  mask;
  logic [7:0]  be8;
  logic [63:0] wd64, rd64;
  assign mask    = size[1] ? 4'b1111 : size[0] ? 4'b0011 : 4'b0001;
  // Both beats come from one 64-bit window: beat 1 holds what spills past lane 3.
  assign be8     = {4'b0000, mask} << off;
  assign be      = hi ? be8[7:4] : be8[3:0];
  assign wd64    = {32'b0, wd} << {off, 3'b000};
  assign lane_wd = hi ? wd64[63:32] : wd64[31:0];
  assign rd64    = (hi ? {rd, lo} : {32'b0, rd}) >> {off, 3'b000};
  assign ld      = size[1] ? rd64[31:0] :
                   size[0] ? {{16{~size[2] & rd64[15]}}, rd64[15:0]} :
                             {{24{~size[2] & rd64[7]}}, rd64[7:0]};
endmodule

// File: rtl/riscv_lsu_split.sv
// riscv_lsu_split: load/store unit issuing one or two word beats per core access.
// RISCV_LSU_MISALIGN_EN splits misaligned accesses; otherwise they fault with no beat.
module riscv_lsu_split
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  riscv_lsu_split_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 2);
  lsu_state_t    state;
  logic [CW-1:0] cnt;
  logic [1:0]    off;
  logic          valid, mis, hi, bad, req, done, last, to;
  logic [31:0]   ld;
  assign off   = bus.core_addr_i[1:0];
  assign valid = bus.core_size_i inside {LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU};
  assign mis   = (bus.core_size_i[1:0] == 2'b01 && off == 2'd3) || (bus.core_size_i == LDST_W && off != 2'd0);
  assign hi    = state == HI;
`ifdef RISCV_LSU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
  logic [31:0] lo_q;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) lo_q <= '0;
    else if (done && mis && !hi) lo_q <= bus.mem_rd_i;
`else
  localparam bit MIS_EN = 1'b0;
  logic [31:0] lo_q;
  assign lo_q = '0;
`endif
  assign bad  = bus.core_req_i && state == IDLE && (!valid || (mis && !MIS_EN));
  // Gating with reset drops a beat in flight the moment reset asserts.
  assign req  = rst_i && bus.core_req_i && (hi || (state == IDLE && !bad));
  assign done = req && bus.mem_ready_i;
  assign last = done && (hi || !mis);
  assign to   = TIMEOUT != 0 && req && !bus.mem_ready_i && 32'(cnt) + 32'd1 == 32'(TIMEOUT);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      cnt   <= (req && !bus.mem_ready_i && !to) ? cnt + CW'(1) : '0;
      state <= state == ERR                   ? IDLE :
               (bad || to)                    ? ERR  :
               (hi && !bus.core_req_i)        ? IDLE :
               (done && mis && MIS_EN && !hi) ? HI   :
               done                           ? IDLE : state;
    end
  riscv_lsu_align u_align (
    .size    (bus.core_size_i),
    .off     (off),
    .hi      (hi),
    .wd      (bus.core_wd_i),
    .rd      (bus.mem_rd_i),
    .lo      (lo_q),
    .be      (bus.mem_be_o),
    .lane_wd (bus.mem_wd_o),
    .ld      (ld)
  );
  assign bus.mem_req_o    = req;
  assign bus.mem_we_o     = bus.core_we_i;
  assign bus.mem_addr_o   = {bus.core_addr_i[ADDR_W-1:2], 2'b00} + (hi ? ADDR_W'(4) : ADDR_W'(0));
  assign bus.core_stall_o = bus.core_req_i && !last && state != ERR;
  assign bus.core_fault_o = state == ERR;
  assign bus.core_rd_o    = (state != ERR && !bus.core_we_i) ? ld : '0;
endmodule

// File: tb/tb_riscv_lsu_split.sv
// tb_riscv_lsu_split: random and directed accesses checked against a byte-level access model.
module tb_riscv_lsu_split;
  import riscv_pkg::*;
  localparam int TO = 4;
`ifdef RISCV_LSU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  riscv_lsu_split_if #(.ADDR_W(32)) bus ();
  riscv_lsu_split #(.ADDR_W(32), .TIMEOUT(TO)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

  int vectors = 0, miscompares = 0;
  int n_beats;
  bit e_bad;
  logic [31:0] e_addr[2], e_wd[2];
  logic [3:0]  e_be[2];
  logic [31:0] o_addr[2], o_wd[2], o_rd;
  logic [3:0]  o_be[2];
  int o_req_cycles;
  bit o_fault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] s);
    return (s == LDST_B || s == LDST_BU) ? 1 : (s == LDST_H || s == LDST_HU) ? 2 : (s == LDST_W) ? 4 : 0;
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Each byte i of the access lives at address a+i: that picks its beat and lane.
  task automatic model(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n, off, p;
    n = size_bytes(sz);
    off = int'(a[1:0]);
    e_be[0] = '0; e_be[1] = '0; e_wd[0] = '0; e_wd[1] = '0;
    n_beats = (n == 0) ? 0 : (off + n > 4) ? 2 : 1;
    e_bad = (n == 0) || (n_beats == 2 && !MIS_EN);
    for (int i = 0; i < n; i++) begin
      p = off + i;
      e_be[p / 4][p % 4] = 1'b1;
      e_wd[p / 4][8 * (p % 4) +: 8] = wd[8 * i +: 8];
    end
    e_addr[0] = {a[31:2], 2'b00};
    e_addr[1] = e_addr[0] + 32'd4;
  endtask

  function automatic logic [31:0] load_val(input logic [2:0] sz, input logic [31:0] a,
                                           input logic [31:0] r0, input logic [31:0] r1);
    logic [31:0] v, w;
    int n, p;
    v = '0;
    n = size_bytes(sz);
    for (int i = 0; i < n; i++) begin
      p = int'(a[1:0]) + i;
      w = (p < 4) ? r0 : r1;
      v[8 * i +: 8] = w[8 * (p % 4) +: 8];
    end
    if (n == 1) v = sz[2] ? {24'b0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    if (n == 2) v = sz[2] ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // Called and returns just after a falling edge; inputs change there, outputs sampled 1 later.
  task automatic run_txn(input logic [2:0] sz, input logic [31:0] a, input bit we, input logic [31:0] wd,
                         input logic [31:0] r0, input logic [31:0] r1, input int w0, input int w1, input int gap);
    int waits[2];
    logic [31:0] rdw[2];
    logic [31:0] e_rd;
    bit timed;
    waits[0] = w0; waits[1] = w1; rdw[0] = r0; rdw[1] = r1;
    model(sz, a, wd);
    e_rd = we ? 32'd0 : load_val(sz, a, r0, r1);
    o_req_cycles = 0; o_fault = 1'b0; timed = 1'b0;
    bus.core_req_i = 1'b1; bus.core_we_i = we; bus.core_size_i = sz; bus.core_addr_i = a; bus.core_wd_i = wd;
    bus.mem_ready_i = 1'b0;
    if (e_bad) begin
      #1;
      chk("bad_req", 32'(bus.mem_req_o), 32'd0);
      chk("bad_stall", 32'(bus.core_stall_o), 32'd1);
      chk("bad_fault0", 32'(bus.core_fault_o), 32'd0);
      @(negedge clk);
      #1;
      o_fault = bus.core_fault_o;
      chk("err_fault", 32'(bus.core_fault_o), 32'd1);
      chk("err_stall", 32'(bus.core_stall_o), 32'd0);
      chk("err_req", 32'(bus.mem_req_o), 32'd0);
      chk("err_rd", bus.core_rd_o, 32'd0);
      @(negedge clk);
    end else begin
      for (int k = 0; k < n_beats && !timed; k++) begin
        int w;
        bit fin, lst;
        w = 0; fin = 1'b0;
        while (!fin && !timed) begin
          bus.mem_ready_i = (w == waits[k]);
          bus.mem_rd_i = bus.mem_ready_i ? rdw[k] : $urandom;
          #1;
          if (bus.mem_req_o) o_req_cycles++;
          o_addr[k] = bus.mem_addr_o; o_be[k] = bus.mem_be_o; o_wd[k] = bus.mem_wd_o;
          chk("mem_req", 32'(bus.mem_req_o), 32'd1);
          chk("mem_addr", bus.mem_addr_o, e_addr[k]);
          chk("mem_be", 32'(bus.mem_be_o), 32'(e_be[k]));
          chk("mem_we", 32'(bus.mem_we_o), 32'(we));
          if (we) chk("mem_wd", bus.mem_wd_o & bmask(e_be[k]), e_wd[k]);
          lst = bus.mem_ready_i && k == n_beats - 1;
          chk("stall", 32'(bus.core_stall_o), 32'(!lst));
          chk("fault", 32'(bus.core_fault_o), 32'd0);
          if (lst) begin
            o_rd = bus.core_rd_o;
            chk("core_rd", bus.core_rd_o, e_rd);
          end
          if (bus.mem_ready_i) fin = 1'b1;
          else if (++w == TO) timed = 1'b1;
          @(negedge clk);
        end
      end
      if (timed) begin
        bus.mem_ready_i = 1'b0;
        #1;
        o_fault = bus.core_fault_o;
        chk("to_fault", 32'(bus.core_fault_o), 32'd1);
        chk("to_stall", 32'(bus.core_stall_o), 32'd0);
        chk("to_req", 32'(bus.mem_req_o), 32'd0);
        chk("to_rd", bus.core_rd_o, 32'd0);
        @(negedge clk);
      end
    end
    bus.core_req_i = 1'b0; bus.mem_ready_i = 1'b0;
    for (int g = 0; g < gap; g++) begin
      #1;
      chk("idle_req", 32'(bus.mem_req_o), 32'd0);
      chk("idle_stall", 32'(bus.core_stall_o), 32'd0);
      chk("idle_fault", 32'(bus.core_fault_o), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] szs[8];
    logic [2:0] sz;
    szs = '{LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU, 3'b011, 3'b110, 3'b111};
    bus.core_req_i = 1'b1; bus.core_we_i = 1'b0; bus.core_size_i = LDST_W; bus.core_addr_i = 32'h0;
    bus.core_wd_i = '0; bus.mem_rd_i = '0; bus.mem_ready_i = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(bus.mem_req_o), 32'd0);
    chk("rst_fault", 32'(bus.core_fault_o), 32'd0);
    chk("rst_stall_req1", 32'(bus.core_stall_o), 32'd1);
    bus.core_req_i = 1'b0;
    #1;
    chk("rst_stall_req0", 32'(bus.core_stall_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(LDST_B, 32'h103, 1'b0, 32'h0, 32'h8000_0000, 32'h0, 0, 0, 1);
    chk("lb_be_lit", 32'(o_be[0]), 32'h8);
    chk("lb_rd_lit", o_rd, 32'hFFFF_FF80);
    chk("lb_beats_lit", o_req_cycles, 1);
    run_txn(LDST_H, 32'h202, 1'b1, 32'h0000_BEEF, 32'h0, 32'h0, 1, 0, 1);
    chk("sh_be_lit", 32'(o_be[0]), 32'hC);
    chk("sh_wd_lit", o_wd[0], 32'hBEEF_0000);
    chk("sh_beats_lit", o_req_cycles, 2);
`ifdef RISCV_LSU_MISALIGN_EN
    run_txn(LDST_W, 32'h301, 1'b0, 32'h0, 32'h4433_2211, 32'h8877_6655, 0, 0, 1);
    chk("lw_a0_lit", o_addr[0], 32'h300);
    chk("lw_be0_lit", 32'(o_be[0]), 32'hE);
    chk("lw_a1_lit", o_addr[1], 32'h304);
    chk("lw_be1_lit", 32'(o_be[1]), 32'h1);
    chk("lw_rd_lit", o_rd, 32'h5544_3322);
`else
    run_txn(LDST_W, 32'h302, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 0, 0, 1);
    chk("sw_mis_beats_lit", o_req_cycles, 0);
    chk("sw_mis_fault_lit", 32'(o_fault), 32'd1);
`endif
    run_txn(LDST_W, 32'h400, 1'b0, 32'h0, 32'h0, 32'h0, 9, 0, 1);
    chk("to_beats_lit", o_req_cycles, 4);
    chk("to_fault_lit", 32'(o_fault), 32'd1);

    // Reset in the middle of an access abandons it; it restarts from beat 0.
    bus.core_req_i = 1'b1; bus.core_we_i = 1'b0; bus.core_size_i = LDST_W; bus.core_addr_i = MIS_EN ? 32'h501 : 32'h500;
    bus.mem_ready_i = MIS_EN; bus.mem_rd_i = 32'h0;
    if (MIS_EN) begin
      @(negedge clk);
      bus.mem_ready_i = 1'b0;
      #1;
      chk("hi_addr", bus.mem_addr_o, 32'h504);
    end
    #1;
    chk("pre_rst_req", 32'(bus.mem_req_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus.mem_req_o), 32'd0);
    chk("mid_rst_stall", 32'(bus.core_stall_o), 32'd1);
    chk("mid_rst_fault", 32'(bus.core_fault_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req", 32'(bus.mem_req_o), 32'd1);
    chk("post_rst_addr", bus.mem_addr_o, 32'h500);
    bus.core_req_i = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 300; t++) begin
      sz = ($urandom_range(0, 19) < 18) ? szs[$urandom_range(0, 4)] : szs[$urandom_range(5, 7)];
      run_txn(sz, $urandom, 1'($urandom), $urandom, $urandom, $urandom,
              ($urandom_range(0, 15) == 0) ? 6 : $urandom_range(0, 3),
              ($urandom_range(0, 15) == 0) ? 6 : $urandom_range(0, 3), $urandom_range(0, 2));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/riscv_lsu_split.md
RISCV_LSU_SPLIT -- requirements
Module: riscv_lsu_split

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of core_addr_i and mem_addr_o.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum cycles waiting for mem_ready_i per beat; 0 disables the timeout.
REQ-003 clk_i  in  1  single clock; all flops on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 core_req_i  in  1  core access request; held stable with its operands while core_stall_o=1.
REQ-006 core_we_i  in  1  1=store, 0=load.
REQ-007 core_size_i  in  3  riscv_pkg LDST_B/H/W/BU/HU.
REQ-008 core_addr_i  in  ADDR_W  byte address, any alignment.
REQ-009 core_wd_i  in  32  store data, right-aligned.
REQ-010 core_rd_o  out  32  load result, extended per size.
REQ-011 core_stall_o  out  1  access in progress; core must hold.
REQ-012 core_fault_o  out  1  one-cycle pulse: access ended with error.
REQ-013 mem_req_o, mem_we_o  out  1 each  memory beat request / write.
REQ-014 mem_be_o  out  4  byte enables.
REQ-015 mem_addr_o  out  ADDR_W  word-aligned address (bits[1:0]=0).
REQ-016 mem_wd_o  out  32  lane-steered write data.
REQ-017 mem_rd_i  in  32  read word, valid when mem_ready_i=1.
REQ-018 mem_ready_i  in  1  completes current beat.

Function
REQ-019 FSM states SHALL be IDLE, HI, ERR.
REQ-020 In IDLE with core_req_i=1 and valid size, first beat SHALL be presented combinationally the same cycle (zero issue latency); beat completes when mem_req_o & mem_ready_i.
REQ-021 off=core_addr_i[1:0]; mem_be_o SHALL be B/BU: 4'b0001<<off, H/HU: 4'b0011<<off, W: 4'b1111<<off, truncated to 4 bits for beat 0.
REQ-022 Access SHALL be misaligned when H/HU with off=3 or W with off!=0; such access needs two beats.
REQ-023 Beat 0 SHALL use address {addr[ADDR_W-1:2],2'b00} and wd<<(8*off); beat 1 SHALL use that address +4 (wrapping modulo 2^ADDR_W), remaining byte enables, and wd>>(8*(4-off)).
REQ-024 On beat-0 completion of a two-beat access: capture mem_rd_i into lo_q, go IDLE->HI, keep stall.
REQ-025 Load result SHALL be ({mem_rd_i,lo_q} or {32'b0,mem_rd_i}) >> (8*off), then sign-extended (B,H) or zero-extended (BU,HU) from bit 7/15; W passes 32 bits.
REQ-026 core_stall_o SHALL equal core_req_i & ~(final beat completing this cycle) & ~(state==ERR); core_rd_o is valid in the cycle stall drops.
REQ-027 Stores SHALL return core_rd_o=0.
REQ-028 A per-beat wait counter SHALL count cycles with mem_req_o=1 & mem_ready_i=0; reaching TIMEOUT (if nonzero) SHALL go to ERR, counter reset on every beat completion.
REQ-029 Invalid size (3'b011, 3'b110, 3'b111) SHALL go to ERR without asserting mem_req_o.
REQ-030 ERR SHALL last one cycle: core_fault_o=1, stall=0, mem_req_o=0, core_rd_o=0, then IDLE.
REQ-031 core_req_i dropping in HI (protocol violation) SHALL return FSM to IDLE with mem_req_o=0 that cycle.

Reset
REQ-032 While rst_i=0: state IDLE, wait counter 0, lo_q 0, mem_req_o=0, core_fault_o=0, core_stall_o=core_req_i.
REQ-033 Reset asserted mid-access SHALL abandon the access; no beat issues until rst_i=1.

Configuration
REQ-034 Macro RISCV_LSU_MISALIGN_EN defined: misaligned accesses split per REQ-022..025.
REQ-035 Macro undefined: misaligned access SHALL go to ERR with no memory beat; state HI and lo_q are not built.

Structure
REQ-036 riscv_pkg SHALL hold LDST_* constants and typedef lsu_state_t {IDLE,HI,ERR}.
REQ-037 Byte-lane steering and load extension SHALL be combinational sub-module riscv_lsu_align.

Verification
REQ-038 LB addr 0x103, mem_rd_i 0x80_00_00_00, ready 1 cycle -> be 4'b1000, core_rd_o 0xFFFFFF80, stall low same cycle.
REQ-039 SH addr 0x202, wd 0x0000BEEF -> be 4'b1100, mem_wd_o 0xBEEF0000, one beat.
REQ-040 (MISALIGN_EN) LW addr 0x301, reads 0x44332211 then 0x88776655 -> beats at 0x300 be 1110, 0x304 be 0001, core_rd_o 0x55443322.
REQ-041 (no MISALIGN_EN) SW addr 0x302 -> no mem_req_o, core_fault_o pulse 1 cycle after request.
REQ-042 TIMEOUT=4, mem_ready_i held 0 -> fault after 4 wait cycles, stall drops, mem_req_o deasserts.
REQ-043 rst_i low during HI beat -> mem_req_o 0 immediately, IDLE after release.
